// File: rtl/hilo_pkg.sv
// Shared opcodes, FSM states and op-decode helpers for the Hi/Lo mul/div unit.
package hilo_pkg;

   localparam logic [5:0] OP_MFHI  = 6'd16;
   localparam logic [5:0] OP_MFLO  = 6'd18;
   localparam logic [5:0] OP_MULT  = 6'd24;
   localparam logic [5:0] OP_MULTU = 6'd25;
   localparam logic [5:0] OP_DIV   = 6'd26;
   localparam logic [5:0] OP_DIVU  = 6'd27;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FINISH
   } state_t;

   function automatic logic op_is_signed(input logic [5:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

   function automatic logic op_is_div(input logic [5:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic op_valid(input logic [5:0] op,
                                     input logic signed_en);
      return (op == OP_MULTU) || (op == OP_DIVU) ||
             (signed_en && op_is_signed(op));
   endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Start/busy/done handshake and Hi/Lo read-back bundle of the mul/div unit.
interface hilo_muldiv_unit_if #(
   parameter int WIDTH = 32
);

   logic             start;
   logic [5:0]       Signal;
   logic [WIDTH-1:0] dataA;
   logic [WIDTH-1:0] dataB;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] Output;

   modport master (
      output start, Signal, dataA, dataB,
      input  busy, done, div_by_zero, Output
   );

   modport slave (
      input  start, Signal, dataA, dataB,
      output busy, done, div_by_zero, Output
   );

endinterface

// File: rtl/muldiv_iter_step.sv
// One shift-add (multiply) or restoring shift-subtract (divide) step.
module muldiv_iter_step #(
   parameter int WIDTH = 32
) (
   input  logic               is_div,
   input  logic [2*WIDTH:0]   acc,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH:0]   acc_nxt
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH+1:0] diff;

   always_comb begin
      sum    = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, b} : '0);
      rem_sh = acc[2*WIDTH-1:WIDTH-1];
      diff   = {1'b0, rem_sh} - {2'b00, b};
      if (is_div) begin
         // borrow means the divisor did not fit: keep the shifted remainder
         if (diff[WIDTH+1])
            acc_nxt = {rem_sh, acc[WIDTH-2:0], 1'b0};
         else
            acc_nxt = {diff[WIDTH:0], acc[WIDTH-2:0], 1'b1};
      end else begin
         acc_nxt = {1'b0, sum, acc[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with Hi/Lo registers and read-back.
import hilo_pkg::*;

module hilo_muldiv_unit #(
   parameter int WIDTH     = 32,
   parameter bit SIGNED_EN = 1'b1
) (
   input logic               clk,
   input logic               reset,
   hilo_muldiv_unit_if.slave bus
);

   localparam int            CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t             state, state_nxt;
   logic [2*WIDTH:0]   acc, acc_nxt;
   logic [CW-1:0]      count;
   logic [WIDTH-1:0]   a_q, b_q, hi, lo, rd;
   logic [WIDTH-1:0]   hi_res, lo_res, abs_a, abs_b, quo, rem;
   logic [2*WIDTH-1:0] prod;
   logic               is_div, neg_p, neg_r, b_zero;
   logic               done_q, dbz_q, accept, sgn_op;

   muldiv_iter_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .is_div (is_div),
      .acc    (acc),
      .b      (b_q),
      .acc_nxt(acc_nxt)
   );

   always_comb begin
      sgn_op = op_is_signed(bus.Signal);
      accept = (state == IDLE) && bus.start &&
               op_valid(bus.Signal, SIGNED_EN);
      abs_a  = (sgn_op && bus.dataA[WIDTH-1]) ? -bus.dataA : bus.dataA;
      abs_b  = (sgn_op && bus.dataB[WIDTH-1]) ? -bus.dataB : bus.dataB;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = RUN;
         RUN:     if (count == LAST) state_nxt = FINISH;
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      prod   = neg_p ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
      quo    = neg_p ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      hi_res = prod[2*WIDTH-1:WIDTH];
      lo_res = prod[WIDTH-1:0];
      if (is_div) begin
         // divide by zero reports the raw dividend, not |dividend|
         if (b_zero) begin
            hi_res = a_q;
            lo_res = '1;
         end else begin
            hi_res = rem;
            lo_res = quo;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         acc    <= '0;
         count  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         is_div <= 1'b0;
         neg_p  <= 1'b0;
         neg_r  <= 1'b0;
         b_zero <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         rd     <= '0;
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= 1'b0;
         if (bus.Signal == OP_MFHI)
            rd <= hi;
         else if (bus.Signal == OP_MFLO)
            rd <= lo;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  acc    <= {{(WIDTH+1){1'b0}}, abs_a};
                  count  <= '0;
                  a_q    <= bus.dataA;
                  b_q    <= abs_b;
                  is_div <= op_is_div(bus.Signal);
                  neg_p  <= sgn_op &&
                            (bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1]);
                  neg_r  <= sgn_op && bus.dataA[WIDTH-1];
                  b_zero <= (bus.dataB == '0);
                  dbz_q  <= 1'b0;
               end
            end
            RUN: begin
               acc   <= acc_nxt;
               count <= count + CW'(1);
            end
            FINISH: begin
               hi     <= hi_res;
               lo     <= lo_res;
               done_q <= 1'b1;
               if (is_div && b_zero)
                  dbz_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy        = (state != IDLE);
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.Output      = rd;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: 32-bit signed, 32-bit unsigned-only, 8-bit.
import hilo_pkg::*;

module tb_hilo_muldiv_unit;

   typedef struct {
      logic        w8;
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic        st;
   logic [5:0]  sig;
   logic [31:0] da, db;
   int          total = 0;
   int          bad = 0;
   exp_t        sb[$];
   vec_t        tv[$];
   logic [31:0] m_lo, u_hi, u_lo;
   logic        u_dbz;

   always #5 clk = ~clk;

   hilo_muldiv_unit_if #(.WIDTH(32)) m_if ();
   hilo_muldiv_unit_if #(.WIDTH(32)) u_if ();
   hilo_muldiv_unit_if #(.WIDTH(8))  n_if ();

   assign m_if.start  = ~sel & st;
   assign m_if.Signal = sel ? 6'd0 : sig;
   assign m_if.dataA  = da;
   assign m_if.dataB  = db;
   assign u_if.start  = m_if.start;
   assign u_if.Signal = m_if.Signal;
   assign u_if.dataA  = da;
   assign u_if.dataB  = db;
   assign n_if.start  = sel & st;
   assign n_if.Signal = sel ? sig : 6'd0;
   assign n_if.dataA  = da[7:0];
   assign n_if.dataB  = db[7:0];

   hilo_muldiv_unit #(.WIDTH(32), .SIGNED_EN(1'b1)) dut_m (
      .clk(clk), .reset(rst), .bus(m_if));
   hilo_muldiv_unit #(.WIDTH(32), .SIGNED_EN(1'b0)) dut_u (
      .clk(clk), .reset(rst), .bus(u_if));
   hilo_muldiv_unit #(.WIDTH(8), .SIGNED_EN(1'b1)) dut_n (
      .clk(clk), .reset(rst), .bus(n_if));

   logic        o_busy, o_done, o_dbz;
   logic [31:0] o_out;

   always_comb begin
      o_busy = sel ? n_if.busy : m_if.busy;
      o_done = sel ? n_if.done : m_if.done;
      o_dbz  = sel ? n_if.div_by_zero : m_if.div_by_zero;
      o_out  = sel ? {24'd0, n_if.Output} : m_if.Output;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic wait_done(output int k);
      for (k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (o_done) break;
      end
   endtask

   task automatic run_op(input vec_t v);
      exp_t e;
      int   k;
      int   w;
      logic uns;
      sel = v.w8;
      w   = v.w8 ? 8 : 32;
      uns = (v.op == OP_MULTU) || (v.op == OP_DIVU);
      @(negedge clk);
      st = 1'b1; sig = v.op; da = v.a; db = v.b;
      sb.push_back('{v.hi, v.lo, v.dbz});
      if (!v.w8 && uns) begin
         u_hi = v.hi; u_lo = v.lo; u_dbz = v.dbz;
      end
      @(negedge clk);
      st = 1'b0; sig = 6'd0;
      chk("busy_after_accept", {31'd0, o_busy}, 32'd1);
      chk("u_busy", {31'd0, u_if.busy}, {31'd0, !v.w8 && uns});
      wait_done(k);
      chk("done_latency", k, w + 1);
      chk("busy_in_done", {31'd0, o_busy}, 32'd0);
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      chk("div_by_zero", {31'd0, o_dbz}, {31'd0, e.dbz});
      sig = OP_MFHI;
      @(negedge clk);
      chk("done_one_cycle", {31'd0, o_done}, 32'd0);
      chk("hi", o_out, e.hi);
      if (!v.w8) chk("u_hi", u_if.Output, u_hi);
      sig = OP_MFLO;
      @(negedge clk);
      chk("lo", o_out, e.lo);
      if (!v.w8) begin
         chk("u_lo", u_if.Output, u_lo);
         chk("u_dbz", {31'd0, u_if.div_by_zero}, {31'd0, u_dbz});
         m_lo = e.lo;
      end
      sig = 6'd0;
   endtask

   initial begin
      int  k;
      int  seen;
      rst = 1'b1; sel = 1'b0; st = 1'b0; sig = 6'd0; da = '0; db = '0;
      m_lo = '0; u_hi = '0; u_lo = '0; u_dbz = 1'b0;

      tv.push_back('{0, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                     32'hFFFFFFFE, 32'h00000001, 0});
      tv.push_back('{0, OP_MULT, 32'hFFFFFFFD, 32'd5,
                     32'hFFFFFFFF, 32'hFFFFFFF1, 0});
      tv.push_back('{0, OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0});
      tv.push_back('{0, OP_DIV, 32'hFFFFFFF9, 32'd2,
                     32'hFFFFFFFF, 32'hFFFFFFFD, 0});
      tv.push_back('{0, OP_DIV, 32'd7, 32'hFFFFFFFE,
                     32'd1, 32'hFFFFFFFD, 0});
      tv.push_back('{0, OP_DIV, 32'h80000000, 32'hFFFFFFFF,
                     32'd0, 32'h80000000, 0});
      tv.push_back('{0, OP_MULT, 32'h80000000, 32'h80000000,
                     32'h40000000, 32'd0, 0});
      tv.push_back('{0, OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1});
      tv.push_back('{0, OP_DIV, 32'hFFFFFFF9, 32'd0,
                     32'hFFFFFFF9, 32'hFFFFFFFF, 1});
      tv.push_back('{0, OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 0});
      tv.push_back('{1, OP_MULTU, 32'hFF, 32'hFF, 32'hFE, 32'h01, 0});
      tv.push_back('{1, OP_MULT, 32'hFD, 32'h05, 32'hFF, 32'hF1, 0});
      tv.push_back('{1, OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0});
      tv.push_back('{1, OP_DIV, 32'hF9, 32'h02, 32'hFF, 32'hFD, 0});
      tv.push_back('{1, OP_DIV, 32'h80, 32'hFF, 32'h00, 32'h80, 0});
      tv.push_back('{1, OP_DIVU, 32'd5, 32'd0, 32'h05, 32'hFF, 1});
      tv.push_back('{1, OP_MULTU, 32'd2, 32'd3, 32'h00, 32'h06, 0});

      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, m_if.busy}, 32'd0);
      chk("rst_done", {31'd0, m_if.done}, 32'd0);
      chk("rst_dbz", {31'd0, m_if.div_by_zero}, 32'd0);
      chk("rst_out", m_if.Output, 32'd0);
      chk("rst_n_out", {24'd0, n_if.Output}, 32'd0);
      rst = 1'b0;

      foreach (tv[i]) run_op(tv[i]);

      // start while busy is dropped; mid-op read sees the old Lo
      sel = 1'b0;
      @(negedge clk);
      st = 1'b1; sig = OP_MULTU; da = 32'd7; db = 32'd9;
      @(negedge clk);
      st = 1'b0; sig = 6'd0;
      repeat (9) @(negedge clk);
      st = 1'b1; sig = OP_DIVU; da = 32'd9; db = 32'd2;
      @(negedge clk);
      st = 1'b0; sig = OP_MFLO;
      @(negedge clk);
      chk("midop_mflo", m_if.Output, m_lo);
      chk("midop_busy", {31'd0, m_if.busy}, 32'd1);
      sig = 6'd0;
      wait_done(k);
      chk("busy_start_done_seen", {31'd0, k <= 60}, 32'd1);
      sig = OP_MFLO;
      @(negedge clk);
      chk("busy_start_lo", m_if.Output, 32'd63);
      sig = OP_MFHI;
      @(negedge clk);
      chk("busy_start_hi", m_if.Output, 32'd0);
      sig = 6'd0;
      @(negedge clk);
      chk("busy_start_idle", {31'd0, m_if.busy}, 32'd0);

      // reset mid-operation abandons it
      @(negedge clk);
      st = 1'b1; sig = OP_MULTU; da = 32'd7; db = 32'd9;
      @(negedge clk);
      st = 1'b0; sig = 6'd0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("reset_busy", {31'd0, m_if.busy}, 32'd0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (m_if.done) seen++;
      end
      chk("reset_no_done", seen, 0);
      sig = OP_MFLO;
      @(negedge clk);
      chk("reset_mflo", m_if.Output, 32'd0);
      sig = OP_MFHI;
      @(negedge clk);
      chk("reset_mfhi", m_if.Output, 32'd0);
      sig = 6'd0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
Parametrised multi-cycle multiply/divide unit with a Hi/Lo result register pair. It is the next generation of the ALU's MULTU/MFHI/MFLO path. It adds signed MULT/DIV, unsigned DIVU, a configurable data width, an explicit start/busy/done handshake and divide-by-zero reporting. It sits beside the single-cycle ALU. The ALU result mux selects Output when Signal is MFHI or MFLO.

Parameters:
WIDTH, 32, operand width; Hi and Lo are each WIDTH bits; must be >= 4.
SIGNED_EN, 1, 1 enables MULT(24) and DIV(26); 0 treats those codes as unknown.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  launches the operation in Signal; sampled only in IDLE
Signal  in  6  function code: MULT 24, MULTU 25, DIV 26, DIVU 27, MFHI 16, MFLO 18
dataA  in  WIDTH  multiplicand / dividend; sampled on the accepting edge
dataB  in  WIDTH  multiplier / divisor; sampled on the accepting edge
busy  out  1  high while state is not IDLE
done  out  1  one-cycle pulse after Hi/Lo are written
div_by_zero  out  1  sticky flag; set by DIV/DIVU with dataB==0, cleared by the next accepted start
Output  out  WIDTH  registered Hi or Lo read-back

Behaviour:
- Reset, on any edge with reset=1, overriding everything: state=IDLE, Hi=0, Lo=0, Output=0, busy=0, done=0, div_by_zero=0. Reset mid-operation abandons the operation and does not write Hi/Lo.
- States:
  - IDLE: on start=1 with a valid op code, latch operands, op and |operands| (signed ops), count=0, then go to RUN. Start with a non-mul/div code is ignored.
  - RUN: one iteration per edge, shift-add for multiply or restoring shift-subtract for divide. After WIDTH iterations go to FINISH.
  - FINISH: apply sign correction, write Hi/Lo, pulse done, go to IDLE.
- Latency: with the accept edge as E0, Hi/Lo are written and done is registered high at edge E(WIDTH+1). done is high for exactly one cycle. busy is high from after E0 through the cycle before E(WIDTH+1) completes; it is low in the done cycle.
- Back-to-back: start may be reasserted in the done cycle. It is accepted at that edge.
- start while busy: ignored, with no queuing and no operand capture.
- Multiply: {Hi,Lo} = full 2*WIDTH product. MULT uses two's-complement operands; MULTU is unsigned.
- Divide: Lo = quotient, Hi = remainder. DIV truncates toward zero, and the remainder takes the sign of the dividend.
- DIV overflow: most-negative / -1 gives Lo = most-negative and Hi = 0, with no flag.
- Divide by zero (DIV/DIVU with dataB==0): still takes full latency. Hi = dataA, Lo = all ones, and div_by_zero is set at the FINISH edge.
- Read-back: on every edge, if Signal==16 then Output<=Hi; if Signal==18 then Output<=Lo; otherwise Output holds. One-cycle latency applies.
- Read-back during busy returns the pre-operation Hi/Lo. A read at edge E(WIDTH+1) returns the old value; a read on the next edge returns the new value.
- Widths: internal accumulator is 2*WIDTH+1 bits; the iteration counter is clog2(WIDTH+1) bits and does not wrap before reaching WIDTH.

Decomposition:
- Shared package hilo_pkg:
  - opcode localparams OP_MFHI=16, OP_MFLO=18, OP_MULT=24, OP_MULTU=25, OP_DIV=26, OP_DIVU=27, matching the ALU's codes
  - state enum {IDLE, RUN, FINISH}
- One sub-module, muldiv_iter_step. It is combinational and does one shift-add or restore-subtract step on the {rem/hi, lo} accumulator. It is instantiated once, and the top FSM registers its output each RUN cycle.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, then MFHI and MFLO -> Hi=0xFFFFFFFE, Lo=0x00000001. done pulses exactly at E33 and busy is low at E33.
- MULT -3 x 5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1. MULT with SIGNED_EN=0 -> ignored: busy stays 0 and Hi/Lo are unchanged.
- DIVU 100/7 -> Lo=14, Hi=2. DIV -7/2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIV 0x80000000 / -1 -> Lo=0x80000000, Hi=0.
- DIVU 5/0 -> Hi=5, Lo=0xFFFFFFFF, div_by_zero=1. The next accepted MULTU 2x3 clears the flag and gives Lo=6.
- Start with DIVU 9/2 while a MULTU is busy (cycle 10) -> ignored; the final Lo equals the MULTU product. MFLO issued mid-op returns the previous Lo.
- Reset asserted at cycle 10 of MULTU 7x9 -> busy=0, done never pulses, a following MFLO returns 0. Repeat the full directed set with WIDTH=8: MULTU 0xFF x 0xFF -> Hi=0xFE, Lo=0x01, done at E9.
